dequantize_int8: RTL
====================

Name: dequantize_int8

Overview:
Streaming INT8-to-fixed-point dequantizer, the inverse of the INT8 quantization step in the face-filter inference datapath. It unpacks LANES signed int8 activations per beat and subtracts a zero point. Each lane is multiplied by a Q16.16 scale, rounded, shifted and saturated to OUT_W-bit signed values. It sits between the int8 activation buffer and the wide-precision post-processing stages, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, int8 lanes per input beat
FRAC_BITS, 16, fractional bits of cfg_scale
OUT_W, 16, signed output width per lane (saturated)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_we  input  1  load cfg_scale/cfg_zero_point
cfg_scale  input  32  signed scale, Q(32-FRAC_BITS).FRAC_BITS
cfg_zero_point  input  8  signed zero point
cfg_err  output  1  one-cycle pulse: cfg_we rejected (busy)
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  LANES*8  packed signed int8, lane 0 in [7:0]
in_last  input  1  end-of-tensor marker
out_valid  output  1  output beat valid
out_ready  input  1  downstream accept
out_data  output  LANES*OUT_W  packed signed results, lane 0 in LSBs
out_last  output  1  in_last delayed with its beat
busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Per lane: d = x - zp (9-bit signed); p = d * scale (41-bit signed).
- Rounding is half away from zero: r = sign(p) * ((|p| + 2^(FRAC_BITS-1)) >> FRAC_BITS).
- Result is r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pipeline: S1 registers the subtract/multiply; S2 registers the round/saturate. Latency is 2 cycles from accept to out_valid when there is no stall.
- Global enable: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_ready. Both stages advance only on adv; a stalled stage holds data and in_last.
- out_data and out_last stay stable while out_valid && !out_ready.
- Bubbles propagate: S1 valid is loaded with in_valid && in_ready on adv.
- Config registers: scale and zp are applied on cfg_we only when !busy && !in_valid.
  - Otherwise the write is ignored and cfg_err pulses for 1 cycle.
  - A beat accepted in the same cycle as a successful load uses the old values. The new values apply from the next accepted beat.
- busy = S1 valid || S2 valid.
- Reset values: scale = 0x0001_0000 (1.0); zp = 0; all stage valids = 0. Outputs out_valid = 0, out_data = 0, out_last = 0, cfg_err = 0, busy = 0. in_ready = 1 once out_valid = 0.
- Reset mid-stream: all in-flight beats are discarded with no partial output, and the next cycle behaves as after power-up.
- Lanes are independent; in_last is carried with the beat unmodified.

Optional Feature:
Macro DEQUANT_SAT_STATS_EN.
- Defined: adds output port sat_count (16 bits), counting output beats in which any lane saturated.
  - Increments on the out_valid && out_ready handshake.
  - Sticks at 0xFFFF.
  - Clears on rst and on a successful cfg_we.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package dequant_pkg holds:
  - typedefs q_int8_t (signed 8) and scale_t (signed 32);
  - constants DEFAULT_SCALE = 32'h0001_0000 and DEFAULT_ZP = 0;
  - a function round_shift_sat(p, frac, out_w).
- One sub-module, dequant_lane: combinational datapath for a single lane, covering subtract, multiply, round and saturate, with the multiply/round split at the stage boundary. It is instantiated LANES times via generate. The top-level module owns the handshake, pipeline valids and config.

Test Plan:
- Identity: reset, stream x = {127, -128, 0, -1}, no cfg -> out = {127, -128, 0, -1} exactly 2 cycles after accept.
- Rounding: cfg scale = 0x0000_8000 (0.5), zp = 0; x = {3, -3, 1, -1} -> {2, -2, 1, -1}.
- Saturation: scale = 0x0100_0000 (256.0), zp = 127.
  - x = -128 -> -32768 (saturated).
  - x = 127 -> 0.
  - Also scale 256.0, zp = -128, x = 127: 255*256 = 65280 -> 32767. sat_count increments when the macro is defined.
- Backpressure: 8 back-to-back beats with out_ready toggling 1/0 pseudo-randomly -> all 8 delivered in order, data stable while stalled, in_last on beat 8 only, no drops or duplicates.
- Config while busy: cfg_we with scale 2.0 while busy = 1 -> cfg_err pulses 1 cycle and outputs still use scale 1.0. cfg_we after the drain -> accepted, and x = 5 -> 10.
- Mid-stream reset: assert rst with 2 beats in flight -> next cycle out_valid = 0, busy = 0, scale back to 1.0, and no stale beat ever appears.

Source files
------------

// File: rtl/dequant_pkg.sv
// dequant_pkg: shared types, reset constants and the round/saturate helper for dequantize_int8
package dequant_pkg;
    typedef logic signed [7:0]  q_int8_t;
    typedef logic signed [31:0] scale_t;

    localparam scale_t  DEFAULT_SCALE = 32'sh0001_0000;
    localparam q_int8_t DEFAULT_ZP    = '0;

    // Round half away from zero, drop frac bits, clamp to an out_w-bit signed range.
    function automatic logic signed [40:0] round_shift_sat(input logic signed [40:0] p, input int frac, input int out_w);
        logic signed [41:0] mag, r, hi, lo;
        mag = p[40] ? -42'(p) : 42'(p);
        r   = (mag + (42'sd1 <<< (frac - 1))) >>> frac;
        r   = p[40] ? -r : r;
        hi  = (42'sd1 <<< (out_w - 1)) - 42'sd1;
        lo  = -(42'sd1 <<< (out_w - 1));
        return (r > hi) ? 41'(hi) : (r < lo) ? 41'(lo) : 41'(r);
    endfunction
endpackage

// File: rtl/dequant_lane.sv
// dequant_lane: one lane of the dequantizer; subtract/multiply feeds S1, round/saturate reads S1
module dequant_lane
    import dequant_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 16
) (
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  zp,
    input  logic signed [31:0] scale,
    output logic signed [40:0] p,
    input  logic signed [40:0] p_q,
    output logic [OUT_W-1:0]   y
`ifdef DEQUANT_SAT_STATS_EN
    ,
    output logic               sat
`endif
);
    logic signed [8:0] d;

    assign d = 9'(x) - 9'(zp);
    assign p = 41'(d) * 41'(scale);
    assign y = OUT_W'(round_shift_sat(p_q, FRAC_BITS, OUT_W));
`ifdef DEQUANT_SAT_STATS_EN
    assign sat = round_shift_sat(p_q, FRAC_BITS, 41) != round_shift_sat(p_q, FRAC_BITS, OUT_W);
`endif
endmodule

// File: rtl/dequantize_int8.sv
// dequantize_int8: 2-stage int8 -> Q fixed-point dequantizer; DEQUANT_SAT_STATS_EN adds sat_count
module dequantize_int8
    import dequant_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [31:0]            cfg_scale,
    input  logic [7:0]             cfg_zero_point,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*8-1:0]     in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
`ifdef DEQUANT_SAT_STATS_EN
    output logic [15:0]            sat_count,
`endif
    output logic                   busy
);
    logic                   adv, cfg_ok, s1_valid, s1_last;
    scale_t                 scale_q;
    q_int8_t                zp_q;
    logic signed [40:0]     p_d [LANES];
    logic signed [40:0]     p_q [LANES];
    logic [LANES*OUT_W-1:0] y_d;
`ifdef DEQUANT_SAT_STATS_EN
    logic [LANES-1:0]       sat_d;
    logic                   out_sat;
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = s1_valid || out_valid;
    assign cfg_ok   = cfg_we && !busy && !in_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dequant_lane #(.FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_lane (
            .x    (in_data[i*8 +: 8]),
            .zp   (zp_q),
            .scale(scale_q),
            .p    (p_d[i]),
            .p_q  (p_q[i]),
            .y    (y_d[i*OUT_W +: OUT_W])
`ifdef DEQUANT_SAT_STATS_EN
            ,
            .sat  (sat_d[i])
`endif
        );
    end

    // Both stages move together on adv; last is masked by valid so bubbles never carry it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
`ifdef DEQUANT_SAT_STATS_EN
            out_sat   <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_last   <= in_valid && in_last;
            p_q       <= p_d;
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            out_data  <= y_d;
`ifdef DEQUANT_SAT_STATS_EN
            out_sat   <= s1_valid && |sat_d;
`endif
        end
    end

    // Config only loads when the pipe is empty and nothing is offered; otherwise flag the reject.
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_q <= DEFAULT_SCALE;
            zp_q    <= DEFAULT_ZP;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                scale_q <= cfg_scale;
                zp_q    <= cfg_zero_point;
            end
        end
    end

`ifdef DEQUANT_SAT_STATS_EN
    // Count delivered beats with any saturated lane; sticky at all-ones, cleared by a new config.
    always_ff @(posedge clk) begin
        if (rst || cfg_ok)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`endif
endmodule
